conv_tile_engine: RTL and testbench

- Parametrised single-clock 2-D convolution engine, successor to the fixed 6x6-image / 2x2-kernel / 6-kernel convolution block.
- Loads one square image row-by-row and a set of square kernels in a burst, then streams every output feature map.
- Adds run-time selectable stride (1 or 2) and signed-kernel mode.
- Sits behind the input-capture stage; output feeds the downstream checker/writeback path.

---
 rtl/conv_tile_engine.sv | 146 ++++++++++++++
 tb/tb_conv_tile_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_engine.sv
// conv_tile_engine: loads a square image and a set of square kernels in one
// burst, then streams every output feature map (kernel-major, row, column).
// Stride 1/2 and signed-weight mode are captured on the first load beat.
module conv_tile_engine #(
    parameter int IMG_DIM = 6,
    parameter int KER_DIM = 2,
    parameter int NUM_KER = 6,
    parameter int PIX_W   = 3,
    parameter int OUT_W   = 8
) (
    input  logic                              clk1,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [IMG_DIM*PIX_W-1:0]          in_row,
    input  logic [KER_DIM*KER_DIM*PIX_W-1:0]  in_kernel,
    input  logic [1:0]                        in_mode,
    output logic                              out_valid,
    output logic [OUT_W-1:0]                  out_data
);
    localparam int L     = (IMG_DIM > NUM_KER) ? IMG_DIM : NUM_KER;
    localparam int KK    = KER_DIM * KER_DIM;
    localparam int OD1   = IMG_DIM - KER_DIM + 1;
    localparam int OD2   = (IMG_DIM - KER_DIM) / 2 + 1;
    localparam int BW    = (L > 1) ? $clog2(L) : 1;
    localparam int DW    = (OD1 > 1) ? $clog2(OD1) : 1;
    localparam int KW    = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
    // Wide enough that the exact sum never wraps before the final truncation.
    localparam int ACC_W = OUT_W + 2 * PIX_W + $clog2(KK + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [BW-1:0]             beat_q;
    logic [1:0]                mode_q;
    logic [KW-1:0]             k_q;
    logic [DW-1:0]             i_q, j_q;
    logic                      out_valid_q;
    logic [OUT_W-1:0]          out_data_q;
    logic [IMG_DIM*PIX_W-1:0]  img_q [IMG_DIM];
    logic [KK*PIX_W-1:0]       ker_q [NUM_KER];

    logic                      load_en, out_en, last_out;
    int                        load_idx, stride, od;
    logic [PIX_W-1:0]          pix, wgt;
    logic signed [ACC_W-1:0]   acc;

    // Geometry for the captured mode and end-of-stream detection.
    always_comb begin
        stride   = mode_q[0] ? 2 : 1;
        od       = mode_q[0] ? OD2 : OD1;
        last_out = (state_q == S_OUT) && (int'(k_q) == NUM_KER - 1) &&
                   (int'(i_q) == od - 1) && (int'(j_q) == od - 1);
    end

    // FSM state register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a frame starts only from IDLE once the last result has left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid && !out_valid_q) state_d = (L == 1) ? S_WAIT : S_LOAD;
            S_LOAD: if (int'(beat_q) == L - 1) state_d = S_WAIT;
            S_WAIT: state_d = S_OUT;
            S_OUT:  if (last_out) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: load strobe with beat index, and compute strobe.
    always_comb begin
        load_en  = ((state_q == S_IDLE) && in_valid && !out_valid_q) || (state_q == S_LOAD);
        load_idx = (state_q == S_LOAD) ? int'(beat_q) : 0;
        out_en   = (state_q == S_OUT);
    end

    // Image and kernel storage; contents are don't-care until loaded.
    always_ff @(posedge clk1) begin
        if (load_en) begin
            for (int t = 0; t < IMG_DIM; t++)
                if (load_idx == t) img_q[t] <= in_row;
            for (int t = 0; t < NUM_KER; t++)
                if (load_idx == t) ker_q[t] <= in_kernel;
        end
    end

    // One output window: unsigned pixels times (optionally signed) weights.
    always_comb begin
        acc = '0;
        for (int r = 0; r < KER_DIM; r++) begin
            for (int c = 0; c < KER_DIM; c++) begin
                pix = '0;
                wgt = '0;
                for (int y = 0; y < IMG_DIM; y++)
                    for (int x = 0; x < IMG_DIM; x++)
                        if (y == int'(i_q) * stride + r && x == int'(j_q) * stride + c)
                            pix = img_q[y][x*PIX_W +: PIX_W];
                for (int n = 0; n < NUM_KER; n++)
                    if (n == int'(k_q)) wgt = ker_q[n][(r*KER_DIM+c)*PIX_W +: PIX_W];
                acc = acc + signed'({{(ACC_W-PIX_W){1'b0}}, pix}) *
                            signed'({{(ACC_W-PIX_W){wgt[PIX_W-1] & mode_q[1]}}, wgt});
            end
        end
    end

    // Beat counter, mode capture, output walk counters and registered output.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            mode_q      <= '0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            beat_q <= load_en ? beat_q + 1'b1 : '0;
            if ((state_q == S_IDLE) && load_en) mode_q <= in_mode;
            if (out_en) begin
                if (int'(j_q) == od - 1) begin
                    j_q <= '0;
                    if (int'(i_q) == od - 1) begin
                        i_q <= '0;
                        k_q <= k_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                k_q <= '0;
                i_q <= '0;
                j_q <= '0;
            end
            out_valid_q <= out_en;
            out_data_q  <= out_en ? acc[OUT_W-1:0] : '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_conv_tile_engine.sv
// Scoreboard bench: two engines (default and 8/3/4/4/12 parameter sets);
// stimulus pushes expected results, per-engine monitors pop and compare.
module tb_conv_tile_engine;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n;
    logic        iv0, ov0, iv1, ov1;
    logic [17:0] row0;
    logic [11:0] ker0;
    logic [1:0]  md0, md1;
    logic [7:0]  od0;
    logic [31:0] row1;
    logic [35:0] ker1;
    logic [11:0] od1;

    conv_tile_engine dut0 (
        .clk1(clk1), .rst_n(rst_n), .in_valid(iv0), .in_row(row0), .in_kernel(ker0),
        .in_mode(md0), .out_valid(ov0), .out_data(od0));

    conv_tile_engine #(.IMG_DIM(8), .KER_DIM(3), .NUM_KER(4), .PIX_W(4), .OUT_W(12)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .in_valid(iv1), .in_row(row1), .in_kernel(ker1),
        .in_mode(md1), .out_valid(ov1), .out_data(od1));

    int checks = 0, failures = 0;
    int q0[$], q1[$];
    int beats0 = 0, beats1 = 0;
    int img[8][8];
    int ker[6][9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the default engine.
    always @(negedge clk1) begin
        if (!rst_n) begin
            q0.delete();
            beats0 = 0;
        end else if (ov0) begin
            beats0++;
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL dut0 unexpected beat data=%0d at %0t", od0, $time);
            end else begin
                check("dut0 data", int'(od0), q0.pop_front());
            end
        end else begin
            check("dut0 data while idle", int'(od0), 0);
        end
    end

    // Monitor for the non-default engine.
    always @(negedge clk1) begin
        if (!rst_n) begin
            q1.delete();
            beats1 = 0;
        end else if (ov1) begin
            beats1++;
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1 unexpected beat data=%0d at %0t", od1, $time);
            end else begin
                check("dut1 data", int'(od1), q1.pop_front());
            end
        end else begin
            check("dut1 data while idle", int'(od1), 0);
        end
    end

    task automatic rand_data(input int pw);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) img[r][c] = int'($urandom_range(0, (1 << pw) - 1));
        for (int k = 0; k < 6; k++)
            for (int e = 0; e < 9; e++) ker[k][e] = int'($urandom_range(0, (1 << pw) - 1));
    endtask

    // Reference convolution straight from the arithmetic definition.
    task automatic push_model(input int which, input int mode);
        int d, k, n, pw, ow, s, od, sum, w;
        d  = which ? 8 : 6;  k  = which ? 3 : 2;  n = which ? 4 : 6;
        pw = which ? 4 : 3;  ow = which ? 12 : 8;
        s  = mode[0] ? 2 : 1;
        od = (d - k) / s + 1;
        for (int kk = 0; kk < n; kk++)
            for (int i = 0; i < od; i++)
                for (int j = 0; j < od; j++) begin
                    sum = 0;
                    for (int r = 0; r < k; r++)
                        for (int c = 0; c < k; c++) begin
                            w = ker[kk][r*k+c];
                            if (mode[1] && w >= (1 << (pw - 1))) w -= (1 << pw);
                            sum += img[i*s+r][j*s+c] * w;
                        end
                    if (which != 0) q1.push_back(sum & ((1 << ow) - 1));
                    else            q0.push_back(sum & ((1 << ow) - 1));
                end
    endtask

    function automatic logic cur_ov(input int which);
        return (which != 0) ? ov1 : ov0;
    endfunction

    function automatic int cur_beats(input int which);
        return (which != 0) ? beats1 : beats0;
    endfunction

    // Drive one frame; optionally poke in_valid during output, or reset mid-output.
    task automatic frame(input int which, input int mode, input bit pulse,
                         input int rst_at, input int exp_total);
        int d, k, n, pw, l, start;
        bit done;
        logic [63:0] r, kk;
        logic [1:0] m;
        d  = which ? 8 : 6;  k = which ? 3 : 2;  n = which ? 4 : 6;  pw = which ? 4 : 3;
        l  = (d > n) ? d : n;
        m  = mode[1:0];
        start = cur_beats(which);
        for (int t = 0; t < l; t++) begin
            r = '0; kk = '0;
            if (t < d) for (int c = 0; c < d; c++) r |= 64'(img[t][c]) << (c * pw);
            if (t < n) for (int e = 0; e < k * k; e++) kk |= 64'(ker[t][e]) << (e * pw);
            if (which != 0) begin
                iv1 = 1'b1; row1 = r[31:0]; ker1 = kk[35:0]; md1 = (t == 0) ? m : ~m;
            end else begin
                iv0 = 1'b1; row0 = r[17:0]; ker0 = kk[11:0]; md0 = (t == 0) ? m : ~m;
            end
            @(posedge clk1); #1;
        end
        iv0 = 1'b0; iv1 = 1'b0;
        check("valid low after last load beat", int'(cur_ov(which)), 0);
        @(posedge clk1); #1;
        check("valid low one edge after load", int'(cur_ov(which)), 0);
        @(posedge clk1); #1;
        check("valid high two edges after load", int'(cur_ov(which)), 1);
        if (pulse) begin
            repeat (5) @(posedge clk1);
            #1;
            for (int p = 0; p < 3; p++) begin
                if (which != 0) begin iv1 = 1'b1; row1 = $urandom; md1 = 2'b11; end
                else            begin iv0 = 1'b1; row0 = 18'($urandom); md0 = 2'b11; end
                @(posedge clk1); #1;
            end
            iv0 = 1'b0; iv1 = 1'b0;
        end
        if (rst_at >= 0) begin
            done = 1'b0;
            for (int c = 0; c < 2000 && !done; c++) begin
                @(negedge clk1); #1;
                if (cur_beats(which) - start >= rst_at) done = 1'b1;
            end
            if (!done) check("reached reset beat", cur_beats(which) - start, rst_at);
            rst_n = 1'b0;
            #1;
            check("valid cleared by reset", int'(ov0), 0);
            check("data cleared by reset", int'(od0), 0);
            @(negedge clk1); #1;
            rst_n = 1'b1;
            @(negedge clk1); #1;
            check("valid low after reset", int'(ov0), 0);
            return;
        end
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk1); #1;
            if (!cur_ov(which) && ((which != 0) ? q1.size() : q0.size()) == 0) done = 1'b1;
        end
        if (!done) check("frame end within budget", 0, 1);
        check("beat count", cur_beats(which) - start, exp_total);
        check("valid low after frame", int'(cur_ov(which)), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; row0 = '0; ker0 = '0; md0 = '0;
        iv1 = 1'b0; row1 = '0; ker1 = '0; md1 = '0;
        #12;
        check("reset dut0 valid", int'(ov0), 0);
        check("reset dut0 data",  int'(od0), 0);
        check("reset dut1 valid", int'(ov1), 0);
        check("reset dut1 data",  int'(od1), 0);
        @(negedge clk1); #1;
        rst_n = 1'b1;

        // All 7s, unsigned stride 1: 4*49 = 196 per beat; in_valid pokes ignored.
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 7;
        for (int k = 0; k < 6; k++) for (int e = 0; e < 9; e++) ker[k][e] = 7;
        repeat (150) q0.push_back(196);
        frame(0, 0, 1'b1, -1, 150);

        // Same data, signed weights (-1): 4*7*(-1) = -28 -> 228, back-to-back frame.
        repeat (150) q0.push_back(228);
        frame(0, 2, 1'b0, -1, 150);

        // Stride 2 ramp: pix[r][c]=(r+c)%8, only w00=k -> ((2i+2j)%8)*k.
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (r + c) % 8;
        for (int k = 0; k < 6; k++) for (int e = 0; e < 9; e++) ker[k][e] = (e == 0) ? k % 8 : 0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) q0.push_back(((2 * i + 2 * j) % 8) * k);
        frame(0, 1, 1'b0, -1, 54);

        // Reset at output beat 40, then a fresh random frame.
        rand_data(3);
        push_model(0, 0);
        frame(0, 0, 1'b0, 40, 150);
        rand_data(3);
        push_model(0, 2);
        frame(0, 2, 1'b0, -1, 150);

        // Non-default parameter set, all four mode combinations.
        rand_data(4); push_model(1, 0); frame(1, 0, 1'b0, -1, 144);
        rand_data(4); push_model(1, 1); frame(1, 1, 1'b0, -1, 36);
        rand_data(4); push_model(1, 2); frame(1, 2, 1'b1, -1, 144);
        rand_data(4); push_model(1, 3); frame(1, 3, 1'b0, -1, 36);

        repeat (3) @(negedge clk1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
